regcheck_harness: RTL and testbench
===================================

Name: regcheck_harness

Overview:
- Synthesizable in-system self-check block that sits between the processor and the register file.
- On start, it runs the CPU for a programmed number of cycles and logs every non-zero register write into a time-stamped trace FIFO.
- It then halts the CPU, takes over regfile read port A, and compares every register against an expected-value ROM.
- It reports the error count, the first failing register, and a pass flag, so on-board test runs no longer need the simulation bench.

Parameters:
- DATA_WIDTH, 32, register/data width
- NUM_REGS, 32, registers checked (indices 0..NUM_REGS-1)
- REG_ADDR_W, 5, register index width; NUM_REGS <= 2**REG_ADDR_W
- CYCLE_W, 16, width of the cycle counter and trace time stamps
- TRACE_DEPTH, 16, trace FIFO entries (power of two, >=2)

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  1-cycle pulse, begins a run; ignored unless state is IDLE
- num_cycles  in  CYCLE_W  run length, sampled on an accepted start
- rwe  in  1  CPU regfile write enable (monitored)
- rd  in  REG_ADDR_W  CPU write register (monitored)
- rdata  in  DATA_WIDTH  CPU write data (monitored)
- cpu_hold  out  1  stall request to CPU, high in CHECK and DONE
- test_mode  out  1  selects test_addr onto regfile read port A
- test_addr  out  REG_ADDR_W  register index under test
- regA  in  DATA_WIDTH  regfile port A read data (combinational read)
- exp_addr  out  REG_ADDR_W  expected-value ROM address
- exp_data  in  DATA_WIDTH  ROM data, valid one cycle after exp_addr
- trace_rd_en  in  1  pop trace FIFO head
- trace_valid  out  1  FIFO non-empty
- trace_data  out  CYCLE_W+REG_ADDR_W+DATA_WIDTH  head entry {cycle, rd, rdata}
- trace_overflow  out  1  sticky: a write was dropped because the FIFO was full
- busy  out  1  state is RUN or CHECK
- done  out  1  high in DONE
- pass  out  1  done and error_count==0
- error_count  out  REG_ADDR_W+1  mismatches found
- first_fail  out  REG_ADDR_W  index of the first mismatch; 0 if none

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; every output is 0, FIFO empty, overflow cleared. Reset mid-run aborts immediately; no partial result is kept.
- States: IDLE -> RUN -> CHECK -> DONE. DONE -> RUN on start, which clears the counters, first_fail, FIFO and overflow.
- IDLE/DONE + start: latch num_cycles and zero cyc. If num_cycles==0, go straight to CHECK; otherwise go to RUN.
- RUN:
  - cyc increments each cycle.
  - A write is logged when rwe && rd!=0, as entry {cyc, rd, rdata}; cyc is the value before the increment (the first RUN cycle is 0).
  - Leave RUN on the cycle where cyc==num_cycles-1; that cycle's write is still logged. Next state is CHECK.
- CHECK, one register per cycle, two-stage pipeline:
  - Cycle k: test_addr=exp_addr=k; regA is captured into a register at the edge ending cycle k.
  - Cycle k+1: compare the captured regA against exp_data.
  - Total CHECK length is NUM_REGS+1 cycles, then DONE.
  - test_mode and cpu_hold are asserted from the first CHECK cycle.
- Mismatch:
  - error_count increments, saturating at all-ones.
  - first_fail is loaded only on the first mismatch.
  - Compare is bitwise over DATA_WIDTH; r0 is checked like any other register.
- DONE: done=1, pass=(error_count==0), cpu_hold=1, test_mode=0. Results hold until reset or the next start.
- Trace FIFO:
  - Logging is active in RUN only. Popping is allowed in any state; trace_data is valid whenever trace_valid=1.
  - Full + log request: entry dropped, trace_overflow set.
  - Simultaneous log and pop while full: pop, then write; nothing is dropped.
  - Pop while empty: ignored.
  - Pointers wrap modulo TRACE_DEPTH.
- start while busy: ignored.

Test Plan:
- Reset, then start with num_cycles=4; rwe=1 with rd=3/rdata=7 at RUN cycle 1 and rd=0/rdata=9 at cycle 2 -> exactly one trace entry {1,3,7}; busy high 4 RUN + 33 CHECK cycles, then done=1.
- ROM matches a regfile holding ri=i for all 32 registers -> error_count=0, pass=1, first_fail=0.
- Regfile differs at r5 (ROM 5, regfile 6) and at r20 -> error_count=2, first_fail=5, pass=0.
- Writes logged on 18 consecutive RUN cycles with no pops -> 16 entries kept, trace_overflow=1; pops then return cycles 0..15 in order.
- reset driven low during CHECK at k=10, then start with num_cycles=0 -> outputs zero after reset; the new run goes directly to CHECK and produces a fresh result.
- start pulsed during RUN -> no effect on cyc or run length.

Source files
------------

// File: rtl/regcheck_harness.sv
// In-system register self-check harness.
// Runs the CPU for a programmed number of cycles while tracing non-zero
// register writes. It then halts the CPU and compares every register,
// read through regfile port A, against an expected-value ROM.
module regcheck_harness #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int CYCLE_W     = 16,
    parameter int TRACE_DEPTH = 16
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [CYCLE_W-1:0]                      num_cycles,
    input  logic                                    rwe,
    input  logic [REG_ADDR_W-1:0]                   rd,
    input  logic [DATA_WIDTH-1:0]                   rdata,
    output logic                                    cpu_hold,
    output logic                                    test_mode,
    output logic [REG_ADDR_W-1:0]                   test_addr,
    input  logic [DATA_WIDTH-1:0]                   regA,
    output logic [REG_ADDR_W-1:0]                   exp_addr,
    input  logic [DATA_WIDTH-1:0]                   exp_data,
    input  logic                                    trace_rd_en,
    output logic                                    trace_valid,
    output logic [CYCLE_W+REG_ADDR_W+DATA_WIDTH-1:0] trace_data,
    output logic                                    trace_overflow,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    pass,
    output logic [REG_ADDR_W:0]                     error_count,
    output logic [REG_ADDR_W-1:0]                   first_fail
);

    localparam int ENTRY_W = CYCLE_W + REG_ADDR_W + DATA_WIDTH;
    localparam int PTR_W   = $clog2(TRACE_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int CHK_W   = REG_ADDR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_CHECK, S_DONE} state_t;

    state_t                  state_reg, state_next;
    logic                    start_ok;
    logic [CYCLE_W-1:0]      cyc_reg, ncyc_reg;
    logic [CHK_W-1:0]        chk_reg;
    logic [DATA_WIDTH-1:0]   cap_reg;
    logic [REG_ADDR_W:0]     err_reg;
    logic [REG_ADDR_W-1:0]   ff_reg;
    logic [REG_ADDR_W-1:0]   cmp_idx;

    logic [ENTRY_W-1:0]      mem [TRACE_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;
    logic                    ovf_reg;
    logic                    log_req, fifo_full, pop_ok, wr_ok;

    // Next-state logic; start is only accepted from IDLE or DONE
    always_comb begin
        state_next = state_reg;
        start_ok   = 1'b0;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = (num_cycles == '0) ? S_CHECK : S_RUN;
                end
            end
            S_RUN: begin
                if (cyc_reg == ncyc_reg - CYCLE_W'(1)) state_next = S_CHECK;
            end
            S_CHECK: begin
                if (chk_reg == CHK_W'(NUM_REGS)) state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register; an active-low reset aborts any run in progress
    always_ff @(posedge clock) begin
        if (!reset) state_reg <= S_IDLE;
        else        state_reg <= state_next;
    end

    // Register index whose captured value is compared this cycle (one behind chk_reg)
    assign cmp_idx = REG_ADDR_W'(chk_reg - CHK_W'(1));

    // Run counter, check pipeline and result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            cyc_reg  <= '0;
            ncyc_reg <= '0;
            chk_reg  <= '0;
            cap_reg  <= '0;
            err_reg  <= '0;
            ff_reg   <= '0;
        end else if (start_ok) begin
            ncyc_reg <= num_cycles;
            cyc_reg  <= '0;
            chk_reg  <= '0;
            err_reg  <= '0;
            ff_reg   <= '0;
        end else begin
            if (state_reg == S_RUN) cyc_reg <= cyc_reg + CYCLE_W'(1);
            if (state_reg == S_CHECK) begin
                chk_reg <= chk_reg + CHK_W'(1);
                cap_reg <= regA;
                // chk_reg==0 has nothing captured yet
                if (chk_reg != '0 && cap_reg != exp_data) begin
                    if (err_reg != '1) err_reg <= err_reg + 1'b1;
                    if (err_reg == '0) ff_reg <= cmp_idx;
                end
            end
        end
    end

    assign log_req   = (state_reg == S_RUN) && rwe && (rd != '0);
    assign fifo_full = (count_reg == CNT_W'(TRACE_DEPTH));
    assign pop_ok    = trace_rd_en && (count_reg != '0);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign wr_ok     = log_req && (!fifo_full || pop_ok);

    // Trace FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clock) begin
        if (!reset || start_ok) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (wr_ok)  wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_reg + CNT_W'(wr_ok) - CNT_W'(pop_ok);
            if (log_req && !wr_ok) ovf_reg <= 1'b1;
        end
    end

    // Trace storage; contents need no reset because occupancy gates the output
    always_ff @(posedge clock) begin
        if (wr_ok) mem[wr_ptr_reg] <= {cyc_reg, rd, rdata};
    end

    assign trace_valid    = (count_reg != '0);
    assign trace_data     = trace_valid ? mem[rd_ptr_reg] : '0;
    assign trace_overflow = ovf_reg;

    assign busy        = (state_reg == S_RUN) || (state_reg == S_CHECK);
    assign done        = (state_reg == S_DONE);
    assign pass        = done && (err_reg == '0);
    assign cpu_hold    = (state_reg == S_CHECK) || (state_reg == S_DONE);
    assign test_mode   = (state_reg == S_CHECK);
    assign test_addr   = (test_mode && chk_reg < CHK_W'(NUM_REGS)) ? chk_reg[REG_ADDR_W-1:0] : '0;
    assign exp_addr    = test_addr;
    assign error_count = err_reg;
    assign first_fail  = ff_reg;

endmodule

// File: tb/tb_regcheck_harness.sv
// Directed testbench for regcheck_harness with a regfile and a ROM model.
module tb_regcheck_harness;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_cycles;
    logic        rwe;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        cpu_hold, test_mode;
    logic [4:0]  test_addr, exp_addr;
    logic [31:0] regA, exp_data;
    logic        trace_rd_en, trace_valid, trace_overflow;
    logic [52:0] trace_data;
    logic        busy, done, pass;
    logic [5:0]  error_count;
    logic [4:0]  first_fail;

    logic [31:0] regfile [32];
    logic [31:0] rom     [32];

    int total = 0;
    int bad   = 0;

    regcheck_harness dut (
        .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
        .rwe(rwe), .rd(rd), .rdata(rdata), .cpu_hold(cpu_hold),
        .test_mode(test_mode), .test_addr(test_addr), .regA(regA),
        .exp_addr(exp_addr), .exp_data(exp_data), .trace_rd_en(trace_rd_en),
        .trace_valid(trace_valid), .trace_data(trace_data),
        .trace_overflow(trace_overflow), .busy(busy), .done(done), .pass(pass),
        .error_count(error_count), .first_fail(first_fail)
    );

    always #5 clock = ~clock;

    // Combinational regfile read port and registered ROM
    assign regA = regfile[test_addr];
    always @(posedge clock) exp_data <= rom[exp_addr];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start(input logic [15:0] n);
        start = 1'b1;
        num_cycles = n;
        step();
        start = 1'b0;
    endtask

    // Counts busy cycles from the current sample until done (bounded)
    task automatic run_count(output int cnt);
        cnt = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (busy) cnt++;
            step();
        end
    endtask

    task automatic pop();
        trace_rd_en = 1'b1;
        step();
        trace_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        total++;
        if ({busy, done, pass, cpu_hold, test_mode, trace_valid, trace_overflow} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=0000000",
                     {busy, done, pass, cpu_hold, test_mode, trace_valid, trace_overflow});
        end
        total++;
        if ({error_count, first_fail, test_addr, trace_data} !== '0) begin
            bad++;
            $display("FAIL reset_values got err=%0d ff=%0d ta=%0d td=%h want all 0",
                     error_count, first_fail, test_addr, trace_data);
        end
        reset = 1'b1;
        step();
        $display("test_reset ok-run complete");
    endtask

    task automatic test_basic();
        int cnt;
        logic [52:0] exp_e;
        cnt = 0;
        do_start(16'd4);
        for (int i = 0; i < 300 && !done; i++) begin
            if (busy) cnt++;
            if (i == 3) begin
                total++;
                if (cpu_hold !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_in_run got=%b want=0", cpu_hold);
                end
            end
            if (i == 4) begin
                total++;
                if ({test_mode, cpu_hold, test_addr} !== {1'b1, 1'b1, 5'd0}) begin
                    bad++;
                    $display("FAIL check_entry got tm=%b hold=%b ta=%0d want 1 1 0",
                             test_mode, cpu_hold, test_addr);
                end
            end
            rwe   = (i == 1) || (i == 2);
            rd    = (i == 1) ? 5'd3 : 5'd0;
            rdata = (i == 1) ? 32'd7 : 32'd9;
            step();
        end
        rwe = 1'b0;
        total++;
        if (cnt !== 37) begin
            bad++;
            $display("FAIL busy_len got=%0d want=37", cnt);
        end
        total++;
        if ({done, pass, error_count, first_fail, test_mode, cpu_hold} !== {1'b1, 1'b1, 6'd0, 5'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL basic_result got done=%b pass=%b err=%0d ff=%0d tm=%b hold=%b want 1 1 0 0 0 1",
                     done, pass, error_count, first_fail, test_mode, cpu_hold);
        end
        exp_e = {16'd1, 5'd3, 32'd7};
        total++;
        if ({trace_valid, trace_data} !== {1'b1, exp_e}) begin
            bad++;
            $display("FAIL basic_trace got v=%b d=%h want v=1 d=%h", trace_valid, trace_data, exp_e);
        end
        pop();
        total++;
        if (trace_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_single_entry got valid=%b want 0", trace_valid);
        end
        $display("test_basic cycles=%0d", cnt);
    endtask

    task automatic test_mismatch();
        int cnt;
        regfile[5]  = 32'd6;
        regfile[20] = 32'd121;
        do_start(16'd1);
        run_count(cnt);
        total++;
        if ({done, pass, error_count, first_fail} !== {1'b1, 1'b0, 6'd2, 5'd5}) begin
            bad++;
            $display("FAIL mismatch got done=%b pass=%b err=%0d ff=%0d want 1 0 2 5",
                     done, pass, error_count, first_fail);
        end
        regfile[5]  = 32'd5;
        regfile[20] = 32'd20;
        $display("test_mismatch err=%0d ff=%0d", error_count, first_fail);
    endtask

    task automatic test_overflow();
        int cnt;
        do_start(16'd18);
        for (int i = 0; i < 18; i++) begin
            rwe   = 1'b1;
            rd    = 5'((i % 31) + 1);
            rdata = 32'(1000 + i);
            step();
        end
        rwe = 1'b0;
        run_count(cnt);
        total++;
        if (trace_overflow !== 1'b1) begin
            bad++;
            $display("FAIL overflow_flag got=%b want=1", trace_overflow);
        end
        for (int j = 0; j < 16; j++) begin
            total++;
            if ({trace_valid, trace_data[52:37], trace_data[31:0]} !== {1'b1, 16'(j), 32'(1000 + j)}) begin
                bad++;
                $display("FAIL overflow_pop%0d got v=%b cyc=%0d data=%0d want 1 %0d %0d",
                         j, trace_valid, trace_data[52:37], trace_data[31:0], j, 1000 + j);
            end
            pop();
        end
        total++;
        if ({trace_valid, trace_overflow} !== 2'b01) begin
            bad++;
            $display("FAIL overflow_drain got v=%b ovf=%b want 0 1", trace_valid, trace_overflow);
        end
        $display("test_overflow drained 16 entries");
    endtask

    task automatic test_start_during_run();
        int cnt;
        logic [52:0] exp_e;
        cnt = 0;
        do_start(16'd6);
        total++;
        if (trace_overflow !== 1'b0) begin
            bad++;
            $display("FAIL start_clears_ovf got=%b want=0", trace_overflow);
        end
        for (int i = 0; i < 300 && !done; i++) begin
            if (busy) cnt++;
            start      = (i == 2);
            num_cycles = 16'd2;
            rwe        = (i == 5);
            rd         = 5'd7;
            rdata      = 32'd55;
            step();
        end
        start = 1'b0;
        rwe   = 1'b0;
        total++;
        if (cnt !== 39) begin
            bad++;
            $display("FAIL busy_start_ignored got=%0d want=39", cnt);
        end
        exp_e = {16'd5, 5'd7, 32'd55};
        total++;
        if ({trace_valid, trace_data} !== {1'b1, exp_e}) begin
            bad++;
            $display("FAIL last_cycle_log got v=%b d=%h want v=1 d=%h", trace_valid, trace_data, exp_e);
        end
        pop();
        $display("test_start_during_run cycles=%0d", cnt);
    endtask

    task automatic test_reset_midcheck();
        int cnt;
        bit hit;
        hit = 1'b0;
        regfile[2] = 32'd77;
        do_start(16'd3);
        rwe   = 1'b1;
        rd    = 5'd4;
        rdata = 32'd5;
        for (int i = 0; i < 100 && !hit; i++) begin
            if (test_mode && test_addr == 5'd10) hit = 1'b1;
            else step();
        end
        total++;
        if (hit !== 1'b1) begin
            bad++;
            $display("FAIL reach_k10 got=%b want=1", hit);
        end
        rwe   = 1'b0;
        reset = 1'b0;
        step();
        total++;
        if ({busy, done, pass, cpu_hold, test_mode, trace_valid, trace_overflow, error_count, first_fail, test_addr, exp_addr, trace_data} !== '0) begin
            bad++;
            $display("FAIL midcheck_reset got busy=%b done=%b hold=%b tm=%b tv=%b err=%0d ta=%0d want all 0",
                     busy, done, cpu_hold, test_mode, trace_valid, error_count, test_addr);
        end
        reset = 1'b1;
        regfile[2] = 32'd2;
        step();
        do_start(16'd0);
        total++;
        if ({busy, test_mode, test_addr} !== {1'b1, 1'b1, 5'd0}) begin
            bad++;
            $display("FAIL zero_len_check got busy=%b tm=%b ta=%0d want 1 1 0", busy, test_mode, test_addr);
        end
        run_count(cnt);
        total++;
        if (cnt !== 33) begin
            bad++;
            $display("FAIL zero_len_busy got=%0d want=33", cnt);
        end
        total++;
        if ({done, pass, error_count, first_fail} !== {1'b1, 1'b1, 6'd0, 5'd0}) begin
            bad++;
            $display("FAIL fresh_result got done=%b pass=%b err=%0d ff=%0d want 1 1 0 0",
                     done, pass, error_count, first_fail);
        end
        $display("test_reset_midcheck cycles=%0d", cnt);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        num_cycles = '0;
        rwe = 1'b0;
        rd = '0;
        rdata = '0;
        trace_rd_en = 1'b0;
        for (int i = 0; i < 32; i++) begin
            regfile[i] = 32'(i);
            rom[i]     = 32'(i);
        end
        test_reset();
        test_basic();
        test_mismatch();
        test_overflow();
        test_start_during_run();
        test_reset_midcheck();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
